// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM states, frame limits,
// default bit-timer width and parity-sense encodings.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // start + 8 data + parity + stop
  localparam int UART_MAX_BITS = 11;
  localparam int UART_CW       = $clog2(UART_MAX_BITS);
  localparam int UART_KW       = 19;

  localparam logic PAR_ODD  = 1'b1;
  localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the idle-high serial line.
// Ports: clk, rst (async, active-high, sets to 1), d in, q out.
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 7/8 data bits, optional parity, one stop bit.
// Ports: clk, rst, rx line, baud_k/eight/pen/ohel config, rd_ack;
//        data, rdy, perr, ferr, ovf status to the host.
module uart_rx
  import uart_pkg::*;
#(
  parameter int KW = UART_KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  input  logic [KW-1:0] baud_k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic          rd_ack,
  output logic [7:0]    data,
  output logic          rdy,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);

  rx_state_e state_q, state_d;

  logic               rx_s;
  logic               rx_d;
  logic [KW-1:0]      tmr_q;
  logic [KW-1:0]      k_q;
  logic [UART_CW-1:0] cnt_q;
  logic [UART_CW-1:0] last;
  logic [8:0]         sh_q;
  logic               eight_q;
  logic               pen_q;
  logic               odd_q;
  logic               tick;
  logic               fall;
  logic               done;
  logic [7:0]         bits;
  logic               par;
  logic               par_exp;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign tick = (tmr_q == KW'(1));

  // rx_d only sees a 1->0 step once the line has been
  // high, so a held-low break cannot retrigger.
  assign fall = rx_d & ~rx_s;

  // index of the final data/parity sample
  assign last = UART_CW'(6)
              + UART_CW'(eight_q)
              + UART_CW'(pen_q);

  assign bits = eight_q ? sh_q[7:0]
                        : {1'b0, sh_q[6:0]};
  assign par  = eight_q ? sh_q[8] : sh_q[7];

  assign par_exp = ^bits ^ (odd_q == PAR_ODD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) state_d = START;
      end
      START: begin
        if (tick) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && cnt_q == last) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d    <= 1'b1;
      tmr_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      odd_q   <= 1'b0;
      data    <= '0;
      rdy     <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      rx_d <= rx_s;

      if (state_q == IDLE) begin
        if (fall) begin
          eight_q <= eight;
          pen_q   <= pen;
          odd_q   <= ohel;
          k_q     <= baud_k;
          tmr_q   <= baud_k >> 1;
        end
      end else if (tick) begin
        tmr_q <= k_q;
      end else begin
        tmr_q <= tmr_q - KW'(1);
      end

      if (state_q == START && tick)
        cnt_q <= '0;

      if (state_q == DATA && tick) begin
        sh_q[cnt_q] <= rx_s;
        cnt_q       <= cnt_q + UART_CW'(1);
      end

      // completion beats a coincident rd_ack
      if (done) begin
        data <= bits;
        perr <= pen_q & (par != par_exp);
        ferr <= ~rx_s;
        rdy  <= 1'b1;
        ovf  <= ~rd_ack & (ovf | rdy);
      end else if (rd_ack) begin
        rdy <= 1'b0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus
// randomized frames against a bit-level reference model.
module tb_uart_rx;

  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [KW-1:0] baud_k;
  logic          eight;
  logic          pen;
  logic          ohel;
  logic          rd_ack;
  logic [7:0]    data;
  logic          rdy;
  logic          perr;
  logic          ferr;
  logic          ovf;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  uart_rx #(.KW(KW)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .baud_k (baud_k),
    .eight  (eight),
    .pen    (pen),
    .ohel   (ohel),
    .rd_ack (rd_ack),
    .data   (data),
    .rdy    (rdy),
    .perr   (perr),
    .ferr   (ferr),
    .ovf    (ovf)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int k, input logic e8,
                         input logic pe, input logic od);
    baud_k = KW'(k);
    eight  = e8;
    pen    = pe;
    ohel   = od;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
  endtask

  // Line-level frame: every bit held k cycles; the line is
  // left at the stop level. scr scrambles config mid-frame.
  task automatic send_frame(input logic [7:0] d,
                            input logic e8, input logic pe,
                            input logic pb, input logic sb,
                            input int k, input bit scr);
    rx = 1'b0;
    cyc(k);
    if (scr) begin
      eight  = 1'($urandom);
      pen    = 1'($urandom);
      ohel   = 1'($urandom);
      baud_k = KW'($urandom_range(4, 40));
    end
    for (int i = 0; i < (e8 ? 8 : 7); i++) begin
      rx = d[i];
      cyc(k);
    end
    if (pe) begin
      rx = pb;
      cyc(k);
    end
    rx = sb;
    cyc(k);
  endtask

  function automatic logic [7:0] m_data(input logic [7:0] d,
                                        input logic e8);
    return e8 ? d : {1'b0, d[6:0]};
  endfunction

  // Error when the count of ones over data+parity has the
  // wrong oddness for the selected sense.
  function automatic logic m_perr(input logic [7:0] d,
                                  input logic e8, input logic pe,
                                  input logic od, input logic pb);
    int ones;
    ones = $countones(m_data(d, e8)) + (pb ? 1 : 0);
    if (!pe) return 1'b0;
    return ((ones % 2) == 1) != od;
  endfunction

  task automatic test_reset();
    rst    = 1'b1;
    rx     = 1'b1;
    rd_ack = 1'b0;
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    cyc(3);
    vecs++; if (data !== 8'h00) begin errs++; $display("FAIL rst_data got %h want 00", data); end
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL rst_rdy got %b want 0", rdy); end
    vecs++; if (perr !== 1'b0) begin errs++; $display("FAIL rst_perr got %b want 0", perr); end
    vecs++; if (ferr !== 1'b0) begin errs++; $display("FAIL rst_ferr got %b want 0", ferr); end
    vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", ovf); end
    rst = 1'b0;
    cyc(4);
  endtask

  task automatic test_8n1_timing();
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      begin
        cyc(154);
        vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL a5_early_rdy got %b want 0", rdy); end
        cyc(1);
        vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL a5_ontime_rdy got %b want 1", rdy); end
      end
    join
    vecs++; if (data !== 8'hA5) begin errs++; $display("FAIL a5_data got %h want a5", data); end
    vecs++; if ({perr, ferr, ovf} !== 3'b000) begin errs++; $display("FAIL a5_flags got %b want 000", {perr, ferr, ovf}); end
    ack();
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL a5_ack_rdy got %b want 0", rdy); end
  endtask

  task automatic test_parity();
    set_cfg(16, 1'b0, 1'b1, 1'b0);
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    vecs++; if (data !== 8'h41) begin errs++; $display("FAIL par_e1_data got %h want 41", data); end
    vecs++; if (perr !== 1'b1) begin errs++; $display("FAIL par_e1_perr got %b want 1", perr); end
    ack();
    send_frame(8'h41, 1'b0, 1'b1, 1'b0, 1'b1, 16, 1'b0);
    vecs++; if (perr !== 1'b0) begin errs++; $display("FAIL par_e0_perr got %b want 0", perr); end
    ack();
    ohel = 1'b1;
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    vecs++; if (perr !== 1'b0) begin errs++; $display("FAIL par_o1_perr got %b want 0", perr); end
    vecs++; if (data !== 8'h41) begin errs++; $display("FAIL par_o1_data got %h want 41", data); end
    ack();
  endtask

  task automatic test_break();
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 16, 1'b0);
    vecs++; if (data !== 8'h3C) begin errs++; $display("FAIL brk_data got %h want 3c", data); end
    vecs++; if (ferr !== 1'b1) begin errs++; $display("FAIL brk_ferr got %b want 1", ferr); end
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL brk_rdy got %b want 1", rdy); end
    ack();
    cyc(16 * 30);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL brk_hold_rdy got %b want 0", rdy); end
    rx = 1'b1;
    cyc(32);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL brk_release_rdy got %b want 0", rdy); end
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    vecs++; if (data !== 8'h96) begin errs++; $display("FAIL brk_next_data got %h want 96", data); end
    vecs++; if (ferr !== 1'b0) begin errs++; $display("FAIL brk_next_ferr got %b want 0", ferr); end
    ack();
  endtask

  task automatic test_glitch();
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(48);
    vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL glitch_rdy got %b want 0", rdy); end
    vecs++; if (data !== 8'h96) begin errs++; $display("FAIL glitch_data got %h want 96", data); end
    vecs++; if ({perr, ferr, ovf} !== 3'b000) begin errs++; $display("FAIL glitch_flags got %b want 000", {perr, ferr, ovf}); end
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    vecs++; if (data !== 8'hC3) begin errs++; $display("FAIL glitch_next_data got %h want c3", data); end
    ack();
  endtask

  task automatic test_back_to_back();
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    vecs++; if (data !== 8'h22) begin errs++; $display("FAIL ovf_data got %h want 22", data); end
    vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_set got %b want 1", ovf); end
    vecs++; if (rdy !== 1'b1) begin errs++; $display("FAIL ovf_rdy got %b want 1", rdy); end
    ack();
    vecs++; if ({rdy, ovf} !== 2'b00) begin errs++; $display("FAIL ovf_ack got %b want 00", {rdy, ovf}); end
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
      begin
        cyc(154);
        rd_ack = 1'b1;
        cyc(1);
        rd_ack = 1'b0;
      end
    join
    vecs++; if ({rdy, ovf} !== 2'b10) begin errs++; $display("FAIL ack_coinc got rdy,ovf=%b want 10", {rdy, ovf}); end
    vecs++; if (data !== 8'h22) begin errs++; $display("FAIL ack_coinc_data got %h want 22", data); end
    ack();
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    d = 8'hF0;
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      cyc(16);
    end
    rx = d[4];
    cyc(8);
    rst = 1'b1;
    cyc(1);
    vecs++; if ({data, rdy, perr, ferr, ovf} !== 12'h000) begin errs++; $display("FAIL midrst_outs got %h want 000", {data, rdy, perr, ferr, ovf}); end
    rst = 1'b0;
    rx  = 1'b1;
    cyc(20);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    vecs++; if (data !== 8'h5A) begin errs++; $display("FAIL midrst_data got %h want 5a", data); end
    vecs++; if ({rdy, perr, ferr, ovf} !== 4'b1000) begin errs++; $display("FAIL midrst_flags got %b want 1000", {rdy, perr, ferr, ovf}); end
    ack();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       e8, pe, od, pb, sb;
    int         k;
    bit         scr;
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      e8  = 1'($urandom);
      pe  = 1'($urandom);
      od  = 1'($urandom);
      pb  = 1'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      scr = 1'($urandom);
      k   = $urandom_range(4, 24);
      set_cfg(k, e8, pe, od);
      send_frame(d, e8, pe, pb, sb, k, scr);
      vecs++; if (data !== m_data(d, e8)) begin errs++; $display("FAIL rnd%0d_data got %h want %h", n, data, m_data(d, e8)); end
      vecs++; if (perr !== m_perr(d, e8, pe, od, pb)) begin errs++; $display("FAIL rnd%0d_perr got %b want %b", n, perr, m_perr(d, e8, pe, od, pb)); end
      vecs++; if (ferr !== ~sb) begin errs++; $display("FAIL rnd%0d_ferr got %b want %b", n, ferr, ~sb); end
      vecs++; if ({rdy, ovf} !== 2'b10) begin errs++; $display("FAIL rnd%0d_rdy got rdy,ovf=%b want 10", n, {rdy, ovf}); end
      rx = 1'b1;
      cyc(k);
      ack();
      vecs++; if (rdy !== 1'b0) begin errs++; $display("FAIL rnd%0d_ack got %b want 0", n, rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_8n1_timing();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive half of the full UART. It deserialises the frame our transmit shift register produces: idle-high line, one start bit (0), 7 data bits LSB first, an optional 8th data bit, an optional parity bit, then a stop bit (1). It presents the received byte with ready, parity, framing and overrun status to the host-side register interface. It runs from the same bit-time value `baud_k` the transmit side uses.

## Interface
- `KW`, default 19: width of `baud_k`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `baud_k`  in  KW  clk cycles per bit; legal range ≥ 4.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `rd_ack`  in  1  one-cycle pulse from the host: byte consumed.
- `data`  out  8  received byte; bit 7 is 0 in 7-bit mode; reset 0x00.
- `rdy`  out  1  byte valid, held until `rd_ack`; reset 0.
- `perr`  out  1  parity error for the current `data`; reset 0.
- `ferr`  out  1  framing error (stop bit sampled 0); reset 0.
- `ovf`  out  1  overrun: a frame completed while `rdy` was 1; reset 0.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. The synchroniser resets to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - A falling edge on `rx_s` latches `eight`, `pen`, `ohel` and `baud_k`.
  - It loads the bit-timer with `baud_k>>1` and enters START.
- START:
  - At timer expiry, sample `rx_s`.
  - If 1: false start; return to IDLE with no status change.
  - If 0: reload the timer with `baud_k`, clear the bit counter, enter DATA.
- DATA:
  - At each timer expiry, sample `rx_s` into the shift register (LSB first) and reload the timer.
  - The state holds for 7 + eight + pen samples, then enters STOP.
- STOP: at timer expiry, sample the stop bit, then on that same edge:
  - Load `data` with the data bits. Bit 7 is forced to 0 when `eight` = 0.
  - `perr` = pen & (received parity ≠ expected). Expected parity is XOR(data bits) for even and ~XOR(data bits) for odd. `perr` = 0 when `pen` = 0.
  - `ferr` = ~stop sample.
  - `ovf` is set if `rdy` was 1 and `rd_ack` is not asserted that cycle.
  - `rdy` is set to 1.
  - Return to IDLE.
- Status registers update only at frame completion. `perr` and `ferr` describe the latest frame.
- `rd_ack` clears `rdy` and `ovf` on the next edge. If `rd_ack` coincides with a frame completion, completion wins: `rdy` stays 1, new data is loaded, and `ovf` is not set.
- Config inputs changing mid-frame have no effect until the next start detection.
- A frame with stop = 0 still delivers data with `ferr` = 1. IDLE then waits for `rx_s` high before arming edge detection, so a held-low break line produces exactly one frame.

## Timing
- Start detect latency: 2 clk of synchroniser plus 1 clk of edge detect.
- Sample points:
  - start bit at `baud_k>>1` after the detected edge;
  - each subsequent bit `baud_k` later.
- Frame completion happens at the stop-bit mid-sample edge. Outputs are visible from that edge onward.
- For an 8N1 frame, completion occurs at (detect + `baud_k>>1` + 9·`baud_k`) cycles.
- The receiver is ready for the next falling edge from the cycle after completion. This gives a half-bit margin for back-to-back frames.
- `rst` mid-frame: immediate return to IDLE, all outputs to reset values, the synchroniser to 1.
- `baud_k` < 4 is unsupported; the bench must not drive it.

## Structure
- Package `uart_pkg` holds:
  - FSM state enum;
  - `UART_MAX_BITS` = 11;
  - default `KW` = 19;
  - parity-sense constants (ODD = 1, EVEN = 0).
- The transmit side shares `uart_pkg` for frame constants.
- One sub-module, `rx_sync2`: a 2-flop synchroniser with asynchronous set-to-1 reset.
- The bit-timer, bit counter and shift register stay inline in `uart_rx`.

## Test plan
- 8N1, `baud_k` = 16, send 0xA5 → `data` = 0xA5, `rdy` = 1 at detect + 8 + 144 cycles, `perr` = `ferr` = `ovf` = 0.
- 7-bit even parity, send 0x41 with parity bit 1 → `data` = 0x41, `perr` = 1. Resend with parity bit 0 → `perr` = 0. Odd sense with parity bit 1 → `perr` = 0.
- 8N1, stop bit driven 0 on 0x3C → `data` = 0x3C, `ferr` = 1. With the line then held low, no second frame until the line returns high.
- `rx` low glitch of 3 clk at `baud_k` = 16 → no `rdy`, FSM back in IDLE, outputs unchanged.
- Two frames 0x11 then 0x22 with no `rd_ack` → `data` = 0x22, `ovf` = 1. Then `rd_ack` → `rdy` = 0, `ovf` = 0. Repeat with `rd_ack` pulsed on the second completion edge → `rdy` = 1, `ovf` = 0.
- Assert `rst` during data bit 4 → all outputs 0 next edge. A following clean 0x5A frame is received correctly.
